// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division,
// one quotient bit per cycle, truncating rounding, denormals flushed to zero.
module fp_div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        dz
);

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

    state_t r_state;
    state_t w_nextState;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [25:0] r_rem;
    logic [24:0] r_quot;
    logic [4:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_dz;

    logic        w_aExpMax, w_bExpMax, w_aZero, w_bZero;
    logic        w_aNan, w_bNan, w_aInf, w_bInf;
    logic        w_special, w_signIn, w_specDz;
    logic [31:0] w_specResult;

    logic [25:0] w_remCur, w_divisor, w_remNext;
    logic        w_ge;

    logic signed [9:0] w_exp;
    logic [22:0]       w_mant;
    logic              w_signReg;

    assign w_aExpMax = &a[30:23];
    assign w_bExpMax = &b[30:23];
    assign w_aZero   = ~|a[30:23];
    assign w_bZero   = ~|b[30:23];
    assign w_aNan    = w_aExpMax & (|a[22:0]);
    assign w_bNan    = w_bExpMax & (|b[22:0]);
    assign w_aInf    = w_aExpMax & ~(|a[22:0]);
    assign w_bInf    = w_bExpMax & ~(|b[22:0]);
    assign w_special = w_aExpMax | w_bExpMax | w_aZero | w_bZero;
    assign w_signIn  = a[31] ^ b[31];

    // Priority matters: NaN-producing combinations first, then inf/x before x/0.
    always_comb begin
        w_specResult = {w_signIn, 31'h0};
        w_specDz     = 1'b0;
        if (w_aNan || w_bNan || (w_aZero && w_bZero) || (w_aInf && w_bInf)) begin
            w_specResult = 32'h7FC00000;
        end else if (w_aInf) begin
            w_specResult = {w_signIn, 8'hFF, 23'h0};
        end else if (w_bZero) begin
            w_specResult = {w_signIn, 8'hFF, 23'h0};
            w_specDz     = 1'b1;
        end else begin
            w_specResult = {w_signIn, 31'h0};
        end
    end

    // The first divide step reads the dividend mantissa straight from the operand register.
    assign w_remCur  = (r_cnt == 5'd0) ? {2'b01, r_a[22:0]} : r_rem;
    assign w_divisor = {2'b01, r_b[22:0]};
    assign w_ge      = (w_remCur >= w_divisor);
    assign w_remNext = w_ge ? (w_remCur - w_divisor) : w_remCur;

    assign w_signReg = r_a[31] ^ r_b[31];
    assign w_exp     = $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]})
                     + (r_quot[24] ? 10'sd127 : 10'sd126);
    assign w_mant    = r_quot[24] ? r_quot[23:1] : r_quot[22:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = w_special ? DONE : DIVIDE;
                end
            end
            DIVIDE: begin
                if (r_cnt == 5'd24) begin
                    w_nextState = NORM;
                end
            end
            NORM: begin
                w_nextState = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_rem    <= 26'h0;
            r_quot   <= 25'h0;
            r_cnt    <= 5'h0;
            r_result <= 32'h0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_rem  <= 26'h0;
                        r_quot <= 25'h0;
                        r_cnt  <= 5'h0;
                        if (w_special) begin
                            r_result <= w_specResult;
                            r_dz     <= w_specDz;
                        end
                    end
                end
                DIVIDE: begin
                    r_quot <= {r_quot[23:0], w_ge};
                    r_rem  <= w_remNext << 1;
                    r_cnt  <= r_cnt + 5'd1;
                end
                NORM: begin
                    r_dz <= 1'b0;
                    if (w_exp >= 10'sd255) begin
                        r_result <= {w_signReg, 8'hFF, 23'h0};
                    end else if (w_exp <= 10'sd0) begin
                        r_result <= {w_signReg, 31'h0};
                    end else begin
                        r_result <= {w_signReg, w_exp[7:0], w_mant};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
    assign dz     = r_dz;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed corner cases plus randomized
// operands compared against an arithmetic reference model.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        dz;

    int checkCount = 0;
    int failCount  = 0;

    fp_div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Quotient taken as one integer division of the scaled mantissas.
    function automatic void refModel(input logic [31:0] ra, input logic [31:0] rb,
                                     output logic [31:0] res, output logic rdz, output logic spec);
        int     ea = int'(ra[30:23]);
        int     eb = int'(rb[30:23]);
        logic   s  = ra[31] ^ rb[31];
        bit     aZ = (ea == 0);
        bit     bZ = (eb == 0);
        bit     aNan = (ea == 255) && (ra[22:0] != 0);
        bit     bNan = (eb == 255) && (rb[22:0] != 0);
        bit     aInf = (ea == 255) && (ra[22:0] == 0);
        bit     bInf = (eb == 255) && (rb[22:0] == 0);
        longint num, den, q;
        int     e;
        logic [22:0] mant;
        spec = 1'b1;
        rdz  = 1'b0;
        if (aNan || bNan || (aZ && bZ) || (aInf && bInf)) begin
            res = 32'h7FC00000;
        end else if (aInf) begin
            res = {s, 8'hFF, 23'h0};
        end else if (bZ) begin
            res = {s, 8'hFF, 23'h0};
            rdz = 1'b1;
        end else if (bInf || aZ) begin
            res = {s, 31'h0};
        end else begin
            spec = 1'b0;
            num  = (longint'(ra[22:0]) + 64'sd8388608) * 64'sd16777216;
            den  = longint'(rb[22:0]) + 64'sd8388608;
            q    = num / den;
            if (q >= 64'sd16777216) begin
                mant = q[23:1];
                e    = ea - eb + 127;
            end else begin
                mant = q[22:0];
                e    = ea - eb + 126;
            end
            if (e >= 255)     res = {s, 8'hFF, 23'h0};
            else if (e <= 0)  res = {s, 31'h0};
            else              res = {s, 8'(e), mant};
        end
    endfunction

    function automatic logic [31:0] randOperand();
        logic        s    = 1'($urandom_range(0, 1));
        int          kind = $urandom_range(0, 15);
        logic [22:0] m    = 23'($urandom);
        logic [7:0]  e;
        case (kind)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; m = 23'h0; end
            2:       begin e = 8'hFF; if (m == 23'h0) m = 23'h1; end
            3:       e = 8'h01;
            4:       e = 8'hFE;
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {s, e, m};
    endfunction

    // Offers one operand pair and returns the cycles until out_valid is seen.
    task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb2, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("inReadyWait", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb2;
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runTransaction(input logic [31:0] ta, input logic [31:0] tb2, input int hold, input string tag);
        logic [31:0] expRes;
        logic        expDz, expSpec;
        int          lat;
        bit          holdBad = 1'b0;
        refModel(ta, tb2, expRes, expDz, expSpec);
        applyStimulus(ta, tb2, lat);
        checkOutput({tag, "_lat"}, 32'(lat), expSpec ? 32'd1 : 32'd27);
        checkOutput({tag, "_res"}, result, expRes);
        checkOutput({tag, "_dz"}, {31'h0, dz}, {31'h0, expDz});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (result !== expRes || dz !== expDz || out_valid !== 1'b1 || in_ready !== 1'b0)
                holdBad = 1'b1;
            in_valid = 1'($urandom_range(0, 1));
            a        = $urandom;
            b        = $urandom;
        end
        if (hold > 0) begin
            checkOutput({tag, "_hold"}, {31'h0, holdBad}, 32'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_idle"}, {30'h0, out_valid, in_ready}, 32'h1);
    endtask

    initial begin
        bit sawValid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("rstOutValid", {31'h0, out_valid}, 32'h0);
        checkOutput("rstResult", result, 32'h0);
        checkOutput("rstDz", {31'h0, dz}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstInReady", {31'h0, in_ready}, 32'h1);

        runTransaction(32'h40C00000, 32'h40000000, 0, "sixByTwo");
        runTransaction(32'h3F800000, 32'h40400000, 0, "oneThird");
        runTransaction(32'hBF800000, 32'h00000000, 0, "divZero");
        runTransaction(32'h00000000, 32'h00000000, 0, "zeroZero");
        runTransaction(32'h7F000000, 32'h3E800000, 0, "overflow");
        runTransaction(32'h00800000, 32'h7F000000, 0, "underflow");
        runTransaction(32'h7F800000, 32'hC0000000, 0, "infFinite");
        runTransaction(32'h40000000, 32'hFF800000, 0, "finiteInf");
        runTransaction(32'h7FC00001, 32'h3F800000, 0, "nanIn");
        runTransaction(32'h40C00000, 32'h40000000, 10, "stallHold");

        // Abort a division part-way; nothing may be presented for it.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h3F800000;
        b        = 32'h40400000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abortOutValid", {31'h0, out_valid}, 32'h0);
        checkOutput("abortResult", result, 32'h0);
        sawValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("abortNoResult", {31'h0, sawValid}, 32'h0);
        runTransaction(32'h40C00000, 32'h40000000, 0, "afterAbort");

        for (int n = 0; n < 200; n++) begin
            runTransaction(randOperand(), randOperand(), $urandom_range(0, 3), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
